refractory_threshold_unit: RTL

Next-generation spike threshold stage for the LIF neuron datapath. It serves NUM_NEURONS neurons time-multiplexed through one valid/ready pipeline slot and compares each updated membrane potential against its threshold. On a spike it either resets the potential to a value or subtracts the threshold, depending on the selected mode. It also holds a per-neuron refractory counter and a global saturating spike counter. It sits between the membrane-update unit and the spike router/membrane writeback.

---
 rtl/threshold_pkg.sv | 52 +++++
 rtl/refractory_counter_bank.sv | 50 +++++
 rtl/refractory_threshold_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/threshold_pkg.sv
// Shared widths, reset-mode encodings and arithmetic helpers for the
// spike threshold stage.
package threshold_pkg;

  localparam int INTEGER_WIDTH_DEF     = 32;
  localparam int DATA_WIDTH_FRAC_DEF   = 32;
  localparam int DATA_WIDTH_DEF        = INTEGER_WIDTH_DEF + DATA_WIDTH_FRAC_DEF;
  localparam int NUM_NEURONS_DEF       = 256;
  localparam int NEURON_ID_WIDTH_DEF   = 8;
  localparam int REFRACT_WIDTH_DEF     = 8;
  localparam int SPIKE_COUNT_WIDTH_DEF = 32;

  // Helpers work at a fixed wide width so any DATA_WIDTH up to CALC_W
  // can use them; callers sign/zero-extend in and slice the result out.
  localparam int CALC_W = 128;

  localparam logic RESET_MODE_VALUE    = 1'b0;
  localparam logic RESET_MODE_SUBTRACT = 1'b1;

  // Integer reset potential placed above the fractional bits.
  function automatic logic [CALC_W-1:0] extend_vreset(
    input logic [CALC_W-1:0] vreset_int,
    input int                frac_bits
  );
    return vreset_int << frac_bits;
  endfunction

  // a - b for signed values of width w (sign-extended to CALC_W), clamped
  // to the signed range of w bits.
  function automatic logic [CALC_W-1:0] sat_sub(
    input logic [CALC_W-1:0] a,
    input logic [CALC_W-1:0] b,
    input int                w
  );
    logic        [CALC_W:0] one_v;
    logic signed [CALC_W:0] diff;
    logic signed [CALC_W:0] max_v;
    logic signed [CALC_W:0] min_v;
    one_v = {{CALC_W{1'b0}}, 1'b1};
    diff  = $signed({a[CALC_W-1], a}) - $signed({b[CALC_W-1], b});
    max_v = $signed((one_v << (w - 1)) - one_v);
    min_v = ~max_v;
    if (diff > max_v) begin
      return max_v[CALC_W-1:0];
    end else if (diff < min_v) begin
      return min_v[CALC_W-1:0];
    end else begin
      return diff[CALC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/refractory_counter_bank.sv
// Per-neuron refractory counters: combinational read, synchronous write,
// out-of-range indices read as zero and are never written.
// Assumes ID_WIDTH >= $clog2(NUM_NEURONS) and NUM_NEURONS >= 2.
module refractory_counter_bank #(
  parameter int NUM_NEURONS   = 256,
  parameter int ID_WIDTH      = 8,
  parameter int REFRACT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ID_WIDTH-1:0]      rd_idx_i,
  output logic [REFRACT_WIDTH-1:0] rd_data_o,
  input  logic                     wr_en_i,
  input  logic [ID_WIDTH-1:0]      wr_idx_i,
  input  logic [REFRACT_WIDTH-1:0] wr_data_i
);

  localparam int IDX_W = $clog2(NUM_NEURONS);

  logic [REFRACT_WIDTH-1:0] cnt_q [NUM_NEURONS];
  logic [IDX_W-1:0]         rd_sel;
  logic [IDX_W-1:0]         wr_sel;
  logic                     rd_in_range;
  logic                     wr_in_range;

  assign rd_sel      = rd_idx_i[IDX_W-1:0];
  assign wr_sel      = wr_idx_i[IDX_W-1:0];
  assign rd_in_range = (32'(rd_idx_i) < NUM_NEURONS);
  assign wr_in_range = (32'(wr_idx_i) < NUM_NEURONS);

  // Read port: absent neurons behave as never refractory.
  always_comb begin
    rd_data_o = '0;
    if (rd_in_range) begin
      rd_data_o = cnt_q[rd_sel];
    end
  end

  // Write port with synchronous clear of the whole bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (wr_en_i && wr_in_range) begin
      cnt_q[wr_sel] <= wr_data_i;
    end
  end

endmodule

// File: rtl/refractory_threshold_unit.sv
// Spike threshold stage: compares the updated membrane potential with the
// threshold, applies reset-to-value or subtract-threshold on a spike,
// tracks per-neuron refractory periods and a saturating spike total.
//
// Handshake: a sample moves on a rising edge when valid && ready are both
// high on that side; InReady = !OutValid || OutReady, and the output slot
// holds its contents unchanged while OutValid && !OutReady.
module refractory_threshold_unit
  import threshold_pkg::*;
#(
  parameter int INTEGER_WIDTH     = INTEGER_WIDTH_DEF,
  parameter int DATA_WIDTH_FRAC   = DATA_WIDTH_FRAC_DEF,
  parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NUM_NEURONS       = NUM_NEURONS_DEF,
  parameter int NEURON_ID_WIDTH   = NEURON_ID_WIDTH_DEF,
  parameter int REFRACT_WIDTH     = REFRACT_WIDTH_DEF,
  parameter int SPIKE_COUNT_WIDTH = SPIKE_COUNT_WIDTH_DEF
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [NEURON_ID_WIDTH-1:0]   NeuronID,
  input  logic [DATA_WIDTH-1:0]        Vth,
  input  logic [DATA_WIDTH-1:0]        Vmem,
  input  logic [INTEGER_WIDTH-1:0]     Vreset,
  input  logic                         ResetMode,
  input  logic [REFRACT_WIDTH-1:0]     RefractPeriod,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [NEURON_ID_WIDTH-1:0]   OutNeuronID,
  output logic [DATA_WIDTH-1:0]        VmemOut,
  output logic                         SpikeOut,
  output logic                         RefractOut,
  output logic [SPIKE_COUNT_WIDTH-1:0] SpikeCount
);

  logic                         out_valid_q, out_valid_d;
  logic [NEURON_ID_WIDTH-1:0]   out_id_q, out_id_d;
  logic [DATA_WIDTH-1:0]        vmem_q, vmem_d;
  logic                         spike_q, spike_d;
  logic                         refr_q, refr_d;
  logic [SPIKE_COUNT_WIDTH-1:0] spike_cnt_q, spike_cnt_d;

  logic                         accept;
  logic [REFRACT_WIDTH-1:0]     cnt;
  logic                         cnt_wr_en;
  logic [REFRACT_WIDTH-1:0]     cnt_wr_data;
  logic                         fire;
  logic [CALC_W-1:0]            vreset_wide;
  logic [CALC_W-1:0]            sub_wide;
  logic [DATA_WIDTH-1:0]        vreset_ext;
  logic [DATA_WIDTH-1:0]        vmem_sub;

  assign InReady = !out_valid_q || OutReady;
  assign accept  = InValid && InReady;

  refractory_counter_bank #(
    .NUM_NEURONS   (NUM_NEURONS),
    .ID_WIDTH      (NEURON_ID_WIDTH),
    .REFRACT_WIDTH (REFRACT_WIDTH)
  ) u_bank (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .rd_idx_i  (NeuronID),
    .rd_data_o (cnt),
    .wr_en_i   (cnt_wr_en),
    .wr_idx_i  (NeuronID),
    .wr_data_i (cnt_wr_data)
  );

  // Fixed-point helpers: reset potential extension and saturating subtract.
  always_comb begin
    vreset_wide = extend_vreset({{(CALC_W-INTEGER_WIDTH){1'b0}}, Vreset},
                                DATA_WIDTH_FRAC);
    sub_wide    = sat_sub({{(CALC_W-DATA_WIDTH){Vmem[DATA_WIDTH-1]}}, Vmem},
                          {{(CALC_W-DATA_WIDTH){Vth[DATA_WIDTH-1]}}, Vth},
                          DATA_WIDTH);
    vreset_ext  = vreset_wide[DATA_WIDTH-1:0];
    vmem_sub    = sub_wide[DATA_WIDTH-1:0];
    fire        = ($signed(Vmem) >= $signed(Vth));
  end

  // Next-state for the output slot, refractory write and spike total.
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    vmem_d      = vmem_q;
    spike_d     = spike_q;
    refr_d      = refr_q;
    spike_cnt_d = spike_cnt_q;
    cnt_wr_en   = 1'b0;
    cnt_wr_data = cnt;

    if (accept) begin
      out_valid_d = 1'b1;
      out_id_d    = NeuronID;
      if (cnt != '0) begin
        vmem_d      = vreset_ext;
        spike_d     = 1'b0;
        refr_d      = 1'b1;
        cnt_wr_en   = 1'b1;
        cnt_wr_data = cnt - REFRACT_WIDTH'(1);
      end else if (fire) begin
        vmem_d      = (ResetMode == RESET_MODE_SUBTRACT) ? vmem_sub : vreset_ext;
        spike_d     = 1'b1;
        refr_d      = 1'b0;
        cnt_wr_en   = 1'b1;
        cnt_wr_data = RefractPeriod;
        if (spike_cnt_q != '1) begin
          spike_cnt_d = spike_cnt_q + SPIKE_COUNT_WIDTH'(1);
        end
      end else begin
        vmem_d  = Vmem;
        spike_d = 1'b0;
        refr_d  = 1'b0;
      end
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot and spike total registers; reset wins over accept.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      vmem_q      <= '0;
      spike_q     <= 1'b0;
      refr_q      <= 1'b0;
      spike_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      vmem_q      <= vmem_d;
      spike_q     <= spike_d;
      refr_q      <= refr_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

  assign OutValid    = out_valid_q;
  assign OutNeuronID = out_id_q;
  assign VmemOut     = vmem_q;
  assign SpikeOut    = spike_q;
  assign RefractOut  = refr_q;
  assign SpikeCount  = spike_cnt_q;

endmodule
